// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Function : Two-requester register-file writeback arbiter with a registered
//            write port and a pending-write bitmap for hazard queries.
// Config   : RF_WB_RR_EN defined   -> round-robin grant pointer (PRI_A/PRI_B)
//            RF_WB_RR_EN undefined -> fixed priority, B always beats A
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        stall,
  input  logic        mark_en,
  input  logic [4:0]  mark_addr,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        busy1,
  output logic        busy2,
  output logic        RFWr,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic        idle
);

  logic [31:0] pending_q, pending_d;
  logic        rfwr_q, rfwr_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd_q, wd_d;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_acc_a;
  logic        w_acc_b;
  logic [4:0]  w_sel_addr;
  logic [31:0] w_sel_data;

`ifdef RF_WB_RR_EN
  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } ptr_t;

  ptr_t ptr_q, ptr_d;

  // Tie-break between simultaneous requesters follows the grant pointer
  always_comb begin
    w_grant_a = a_valid && (!b_valid || (ptr_q == PRI_A));
    w_grant_b = b_valid && !w_grant_a;
  end

  // Pointer moves away from whichever requester was just served
  always_comb begin
    ptr_d = ptr_q;
    if (w_acc_a) begin
      ptr_d = PRI_B;
    end else if (w_acc_b) begin
      ptr_d = PRI_A;
    end
  end

  // Grant pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= PRI_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: B (load/multi-cycle) always beats A (ALU)
  always_comb begin
    w_grant_b = b_valid;
    w_grant_a = a_valid && !b_valid;
  end
`endif

  // Readies are gated by reset and stall; at most one can be high
  assign a_ready = rst && !stall && w_grant_a;
  assign b_ready = rst && !stall && w_grant_b;
  assign w_acc_a = a_valid && a_ready;
  assign w_acc_b = b_valid && b_ready;

  assign w_sel_addr = w_acc_b ? b_addr : a_addr;
  assign w_sel_data = w_acc_b ? b_data : a_data;

  // Next write-port state: pulse RFWr only for accepted non-zero destinations
  always_comb begin
    rfwr_d = 1'b0;
    a3_d   = a3_q;
    wd_d   = wd_q;
    if ((w_acc_a || w_acc_b) && (w_sel_addr != 5'd0)) begin
      rfwr_d = 1'b1;
      a3_d   = w_sel_addr;
      wd_d   = w_sel_data;
    end
  end

  // Pending bitmap: commit clears, issue marks, mark wins on collision
  always_comb begin
    pending_d = pending_q;
    if (rfwr_q) begin
      pending_d[a3_q] = 1'b0;
    end
    if (mark_en && (mark_addr != 5'd0)) begin
      pending_d[mark_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Write port and bitmap registers; reset drops any in-flight write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rfwr_q    <= 1'b0;
      a3_q      <= 5'd0;
      wd_q      <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      rfwr_q    <= rfwr_d;
      a3_q      <= a3_d;
      wd_q      <= wd_d;
      pending_q <= pending_d;
    end
  end

  assign RFWr  = rfwr_q;
  assign A3    = a3_q;
  assign WD    = wd_q;
  assign busy1 = pending_q[q_rs1];
  assign busy2 = pending_q[q_rs2];
  assign idle  = (pending_q == 32'd0) && !rfwr_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Function : Directed, scoreboard-checked bench for rf_wb_arbiter. Expected
//            writes are queued at issue and retired by a negedge monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        stall;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic [4:0]  q_rs1, q_rs2;
  logic        busy1, busy2;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic        idle;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  logic exp_a;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .stall(stall), .mark_en(mark_en), .mark_addr(mark_addr),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .busy1(busy1), .busy2(busy2),
    .RFWr(RFWr), .A3(A3), .WD(WD), .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One request cycle: drive, check readies, queue the expected write,
  // then let the edge happen and withdraw the requests.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic ea, input logic eb, input string tag);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    chk({tag, "_a_ready"}, {31'd0, a_ready}, {31'd0, ea});
    chk({tag, "_b_ready"}, {31'd0, b_ready}, {31'd0, eb});
    chk({tag, "_ready_excl"}, {31'd0, a_ready && b_ready}, 32'd0);
    if (ea && aa != 5'd0) exp_q.push_back(wr_t'{addr: aa, data: ad, cyc: cyc_cnt + 1});
    if (eb && ba != 5'd0) exp_q.push_back(wr_t'{addr: ba, data: bd, cyc: cyc_cnt + 1});
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Monitor: every RFWr pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (RFWr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {27'd0, A3}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_cycle", cyc_cnt, mon_e.cyc);
          chk("wr_A3", {27'd0, A3}, {27'd0, mon_e.addr});
          chk("wr_WD", WD, mon_e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        mon_e = exp_q.pop_front();
        chk("missing_write", {27'd0, mon_e.addr} | 32'h8000_0000, {27'd0, mon_e.addr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; mark_en = 1'b0; mark_addr = 5'd0;
    q_rs1 = 5'd0; q_rs2 = 5'd0;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h9;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_RFWr", {31'd0, RFWr}, 32'd0);
    chk("rst_A3", {27'd0, A3}, 32'd0);
    chk("rst_WD", WD, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Basic write, accepted on the first edge after reset release
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "first");
    #1;
    chk("first_RFWr_hi", {31'd0, RFWr}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, "gap");
    #1;
    chk("first_RFWr_lo", {31'd0, RFWr}, 32'd0);
    chk("hold_A3", {27'd0, A3}, 32'd5);
    chk("hold_WD", WD, 32'h1234);

    // Lone B leaves a round-robin pointer back at A
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b0, 1'b1, "lone_b");

    // Contention for four cycles
    for (int i = 0; i < 4; i++) begin
`ifdef RF_WB_RR_EN
      exp_a = (i % 2 == 0);
`else
      exp_a = 1'b0;
`endif
      step(1'b1, 5'd10, 32'hAAAA_0001, 1'b1, 5'd11, 32'hBBBB_0001, exp_a, !exp_a, "both");
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, "idle1");

    // Pending mark, query, clear on commit
    mark_en = 1'b1; mark_addr = 5'd7; q_rs1 = 5'd7; q_rs2 = 5'd11;
    #1;
    chk("mark_pre_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    mark_en = 1'b0;
    #1;
    chk("mark_busy1", {31'd0, busy1}, 32'd1);
    chk("mark_busy2", {31'd0, busy2}, 32'd0);
    chk("mark_idle", {31'd0, idle}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7777, 1'b0, 1'b1, "wb7");
    #1;
    chk("no_bypass_busy1", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    #1;
    chk("cleared_busy1", {31'd0, busy1}, 32'd0);
    chk("cleared_idle", {31'd0, idle}, 32'd1);

    // Mark and commit on the same register at the same edge
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7A7A, 1'b0, 1'b1, "wb7b");
    mark_en = 1'b1; mark_addr = 5'd7;
    @(negedge clk);
    mark_en = 1'b0;
    #1;
    chk("mark_wins_busy1", {31'd0, busy1}, 32'd1);
    chk("mark_wins_idle", {31'd0, idle}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7B7B, 1'b0, 1'b1, "wb7c");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, "idle2");
    #1;
    chk("cleanup_busy1", {31'd0, busy1}, 32'd0);
    chk("cleanup_idle", {31'd0, idle}, 32'd1);

    // Writes to register 0 are accepted but never reach the port
    q_rs1 = 5'd0;
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "addr0");
    #1;
    chk("addr0_RFWr", {31'd0, RFWr}, 32'd0);
    chk("addr0_idle", {31'd0, idle}, 32'd1);
    chk("addr0_busy_r0", {31'd0, busy1}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, "idle3");
    #1;
    chk("addr0_RFWr_after", {31'd0, RFWr}, 32'd0);
    chk("addr0_idle_after", {31'd0, idle}, 32'd1);

    // Stall blocks both requesters, then acceptance resumes
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd12, 32'hC0C0, 1'b1, 5'd13, 32'hD0D0, 1'b0, 1'b0, "stall");
    end
    stall = 1'b0;
    step(1'b1, 5'd12, 32'hC0C0, 1'b1, 5'd13, 32'hD0D0, 1'b0, 1'b1, "unstall");
    step(1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "a_after");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, "idle4");

    // Reset in the cycle where a write is on the port
    mark_en = 1'b1; mark_addr = 5'd9; q_rs1 = 5'd9;
    step(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "pre_rst");
    mark_en = 1'b0;
    a_valid = 1'b1; a_addr = 5'd21; a_data = 32'h2121;
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_RFWr", {31'd0, RFWr}, 32'd0);
    chk("midrst_A3", {27'd0, A3}, 32'd0);
    chk("midrst_WD", WD, 32'd0);
    chk("midrst_idle", {31'd0, idle}, 32'd1);
    chk("midrst_busy1", {31'd0, busy1}, 32'd0);
    chk("midrst_a_ready", {31'd0, a_ready}, 32'd0);
    a_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("postrst_RFWr", {31'd0, RFWr}, 32'd0);
    chk("postrst_idle", {31'd0, idle}, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
